frame_sequencer: RTL and testbench
==================================

FRAME_SEQUENCER -- requirements
Module: frame_sequencer

Interface
REQ-001 The module SHALL have parameter WIDTH, default 720, meaning pixels per line.
REQ-002 The module SHALL have parameter HEIGHT, default 540, meaning lines per frame; N = WIDTH*HEIGHT (388800 at default).
REQ-003 The module SHALL have parameter TIMEOUT, default 1048576, meaning the number of consecutive idle cycles before abort.
REQ-004 Port clock, input, 1 bit: the only clock; all logic is rising-edge.
REQ-005 Port reset, input, 1 bit: synchronous, active-low reset.
REQ-006 Port start, input, 1 bit: one-cycle frame request.
REQ-007 Port busy, output, 1 bit: high in RUN or DRAIN.
REQ-008 Port done, output, 1 bit: one-cycle pulse on frame completion.
REQ-009 Port timeout_err, output, 1 bit: sticky abort flag.
REQ-010 Ports src_empty (input, 1), src_rd_en (output, 1), src_dout (input, 24): the source FIFO, first-word-fall-through.
REQ-011 Ports img_full (input, 1), img_wr_en (output, 1), img_din (output, 24): the edge-detect pipeline input FIFO.
REQ-012 Ports res_empty (input, 1), res_rd_en (output, 1), res_dout (input, 8): the pipeline result FIFO, first-word-fall-through.
REQ-013 Ports snk_full (input, 1), snk_wr_en (output, 1), snk_din (output, 8): the sink FIFO.
REQ-014 Ports in_count and out_count, output, 20 bits each: pixels forwarded and pixels collected in the current or last frame.

Function
REQ-015 The FSM SHALL have exactly four states: IDLE, RUN, DRAIN, DONE.
REQ-016 IDLE -> RUN SHALL occur on start=1; in_count and out_count SHALL clear to 0 and the idle timer SHALL clear on the same edge.
REQ-017 In RUN, img_wr_en SHALL be combinationally (!src_empty && !img_full && in_count<N).
REQ-018 src_rd_en SHALL equal img_wr_en, and img_din SHALL equal src_dout (zero-latency pass-through).
REQ-019 In RUN and DRAIN, res_rd_en SHALL be combinationally (!res_empty && !snk_full && out_count<N).
REQ-020 snk_wr_en SHALL equal res_rd_en, and snk_din SHALL equal res_dout.
REQ-021 in_count SHALL increment by 1 on each edge where img_wr_en=1; out_count SHALL increment by 1 on each edge where res_rd_en=1.
REQ-022 Counter widths: 20-bit unsigned; N SHALL fit in 20 bits, and neither counter SHALL ever exceed N (no wrap).
REQ-023 RUN -> DRAIN SHALL occur on the edge where in_count becomes N.
REQ-024 DRAIN -> DONE SHALL occur on the edge where out_count becomes N.
REQ-025 A simultaneous final input and final output transfer in RUN SHALL go directly RUN -> DONE.
REQ-026 DONE SHALL last exactly one cycle with done=1, then return to IDLE.
REQ-027 In all states other than RUN/DRAIN, all four FIFO enables SHALL be 0.
REQ-028 start SHALL be ignored in RUN, DRAIN and DONE; no queuing.
REQ-029 start in IDLE on the cycle after DONE SHALL be accepted normally.
REQ-030 Idle timer: in RUN/DRAIN, the timer SHALL increment on every cycle with img_wr_en=0 and res_rd_en=0, and clear on any transfer.
REQ-031 When the idle timer reaches TIMEOUT, the FSM SHALL go to IDLE, set timeout_err=1, and SHALL NOT pulse done.
REQ-032 timeout_err SHALL clear only on the next accepted start or on reset.
REQ-033 Counters SHALL hold their values in IDLE and DONE for software readback.
REQ-034 busy SHALL be registered from state: high in RUN or DRAIN, otherwise low.

Reset
REQ-035 On reset=0 at a rising edge: state=IDLE, in_count=0, out_count=0, idle timer=0, done=0, timeout_err=0, busy=0.
REQ-036 Reset SHALL take priority over all other inputs, including mid-frame; FIFO enables SHALL be 0 on the following cycle.
REQ-037 Reset SHALL NOT clear external FIFOs; flushing them is the top level's responsibility.

Verification
REQ-038 WIDTH=4, HEIGHT=2, source preloaded with 8 pixels, pipeline looped back with 1-cycle FIFO, sink never full, start pulse -> in_count=8, out_count=8, done high one cycle, busy low after.
REQ-039 img_full held high for 50 cycles mid-frame -> no img_wr_en during stall, no src_rd_en, in_count frozen, resumes with no lost or duplicated pixel (sink data matches source order).
REQ-040 TIMEOUT=16, source empty after 3 pixels -> after 16 idle cycles state=IDLE, timeout_err=1, done never pulses, in_count=3 held.
REQ-041 start repeated every cycle during RUN -> ignored, counters unaffected; start on cycle after done -> new frame, counters restart at 0, timeout_err cleared.
REQ-042 reset=0 asserted while in DRAIN with out_count=5 -> next cycle all outputs at reset values and all enables 0.
REQ-043 WIDTH=1, HEIGHT=1 with last input and output on the same edge -> RUN -> DONE directly, done pulse on the next cycle.

Source files
------------

// File: rtl/frame_sequencer_if.sv
// Control, status and FIFO handshake bundle between frame_sequencer and its surrounding FIFOs.
// The master side is the sequencer; the slave side is the environment (FIFOs and software).
interface frame_sequencer_if;
   logic        start;
   logic        busy;
   logic        done;
   logic        timeout_err;
   logic        src_empty;
   logic        src_rd_en;
   logic [23:0] src_dout;
   logic        img_full;
   logic        img_wr_en;
   logic [23:0] img_din;
   logic        res_empty;
   logic        res_rd_en;
   logic [7:0]  res_dout;
   logic        snk_full;
   logic        snk_wr_en;
   logic [7:0]  snk_din;
   logic [19:0] in_count;
   logic [19:0] out_count;

   modport master (
      input  start, src_empty, src_dout, img_full, res_empty, res_dout, snk_full,
      output busy, done, timeout_err, src_rd_en, img_wr_en, img_din,
             res_rd_en, snk_wr_en, snk_din, in_count, out_count
   );

   modport slave (
      output start, src_empty, src_dout, img_full, res_empty, res_dout, snk_full,
      input  busy, done, timeout_err, src_rd_en, img_wr_en, img_din,
             res_rd_en, snk_wr_en, snk_din, in_count, out_count
   );
endinterface

// File: rtl/frame_sequencer.sv
// Frame sequencer: streams one frame of pixels from the source FIFO into the edge-detect
// pipeline and collects the same number of results into the sink FIFO, with an idle-abort timer.
module frame_sequencer #(
   parameter int WIDTH   = 720,
   parameter int HEIGHT  = 540,
   parameter int TIMEOUT = 1048576
) (
   input  logic              clock,
   input  logic              reset,
   frame_sequencer_if.master bus
);
   localparam int          N_INT      = WIDTH * HEIGHT;
   localparam logic [19:0] N          = 20'(N_INT);
   localparam int          TW         = $clog2(TIMEOUT + 1);
   localparam logic [TW-1:0] TIMEOUT_M1 = TW'(TIMEOUT - 1);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

   state_t        state_reg;
   logic [19:0]   in_count_reg;
   logic [19:0]   out_count_reg;
   logic [TW-1:0] idle_timer_reg;
   logic          busy_reg;
   logic          done_reg;
   logic          timeout_err_reg;

   logic          in_xfer;
   logic          out_xfer;
   logic [19:0]   in_count_next;
   logic [19:0]   out_count_next;

   // Transfers are gated by the count so neither side can move more than N words per frame.
   always_comb begin
      in_xfer        = (state_reg == RUN) && !bus.src_empty && !bus.img_full &&
                       (in_count_reg < N);
      out_xfer       = ((state_reg == RUN) || (state_reg == DRAIN)) && !bus.res_empty &&
                       !bus.snk_full && (out_count_reg < N);
      in_count_next  = in_count_reg + {19'd0, in_xfer};
      out_count_next = out_count_reg + {19'd0, out_xfer};
   end

   assign bus.src_rd_en   = in_xfer;
   assign bus.img_wr_en   = in_xfer;
   assign bus.img_din     = bus.src_dout;
   assign bus.res_rd_en   = out_xfer;
   assign bus.snk_wr_en   = out_xfer;
   assign bus.snk_din     = bus.res_dout;
   assign bus.busy        = busy_reg;
   assign bus.done        = done_reg;
   assign bus.timeout_err = timeout_err_reg;
   assign bus.in_count    = in_count_reg;
   assign bus.out_count   = out_count_reg;

   always_ff @(posedge clock) begin
      if (!reset) begin
         state_reg       <= IDLE;
         in_count_reg    <= '0;
         out_count_reg   <= '0;
         idle_timer_reg  <= '0;
         busy_reg        <= 1'b0;
         done_reg        <= 1'b0;
         timeout_err_reg <= 1'b0;
      end else begin
         done_reg <= 1'b0;
         case (state_reg)
            IDLE: begin
               if (bus.start) begin
                  state_reg       <= RUN;
                  in_count_reg    <= '0;
                  out_count_reg   <= '0;
                  idle_timer_reg  <= '0;
                  timeout_err_reg <= 1'b0;
                  busy_reg        <= 1'b1;
               end
            end
            RUN, DRAIN: begin
               in_count_reg  <= in_count_next;
               out_count_reg <= out_count_next;
               if (in_xfer || out_xfer) begin
                  idle_timer_reg <= '0;
               end else begin
                  idle_timer_reg <= idle_timer_reg + TW'(1);
               end
               // Abort only fires on an idle cycle, so it never competes with completion.
               if (!in_xfer && !out_xfer && (idle_timer_reg == TIMEOUT_M1)) begin
                  state_reg       <= IDLE;
                  timeout_err_reg <= 1'b1;
                  busy_reg        <= 1'b0;
               end else if ((in_count_next == N) && (out_count_next == N)) begin
                  state_reg <= DONE;
                  done_reg  <= 1'b1;
                  busy_reg  <= 1'b0;
               end else if (in_count_next == N) begin
                  state_reg <= DRAIN;
               end
            end
            DONE: begin
               state_reg <= IDLE;
            end
            default: begin
               state_reg <= IDLE;
               busy_reg  <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_frame_sequencer.sv
// Scoreboard bench for frame_sequencer: a 4x2 instance driven by randomized FIFO models and a
// 1x1 instance driven directly for the simultaneous-finish and short-timeout cases.
module tb_frame_sequencer;
   localparam int N_A       = 8;
   localparam int TIMEOUT_A = 64;
   localparam int TIMEOUT_B = 16;

   logic clock;
   logic reset;

   frame_sequencer_if bus_a ();
   frame_sequencer_if bus_b ();

   frame_sequencer #(.WIDTH(4), .HEIGHT(2), .TIMEOUT(TIMEOUT_A)) dut_a (
      .clock (clock),
      .reset (reset),
      .bus   (bus_a)
   );

   frame_sequencer #(.WIDTH(1), .HEIGHT(1), .TIMEOUT(TIMEOUT_B)) dut_b (
      .clock (clock),
      .reset (reset),
      .bus   (bus_b)
   );

   initial begin
      clock = 1'b0;
      forever #5 clock = ~clock;
   end

   int total = 0;
   int bad   = 0;

   logic [23:0] src_q[$];
   logic [7:0]  pipe_q[$];
   logic [7:0]  exp_q[$];
   bit          rand_on    = 1'b0;
   bit          force_full = 1'b0;
   int          out_cap    = 1000000;
   int          res_taken  = 0;
   int          cyc        = 0;
   int          last_xfer_cyc = 0;
   int          done_cnt   = 0;
   int          snk_cnt    = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
      end else begin
         $display("ok   %s: 0x%0h", name, act);
      end
   endtask

   // Edge-detect stand-in: any fixed per-pixel function keeps ordering observable.
   function automatic logic [7:0] pix_fn(input logic [23:0] p);
      return p[7:0] ^ p[15:8] ^ p[23:16] ^ 8'h5a;
   endfunction

   task automatic load_pixels(input int n);
      logic [23:0] p;
      for (int i = 0; i < n; i++) begin
         p = 24'($urandom);
         src_q.push_back(p);
         exp_q.push_back(pix_fn(p));
      end
   endtask

   // Main sample point: 4 time units after the falling edge, 1 unit before the rising edge.
   task automatic tick();
      @(negedge clock);
      #4;
   endtask

   task automatic check_idle_a(input string tag);
      check({tag, "_busy"},      32'(bus_a.busy),        32'd0);
      check({tag, "_done"},      32'(bus_a.done),        32'd0);
      check({tag, "_terr"},      32'(bus_a.timeout_err), 32'd0);
      check({tag, "_in_count"},  32'(bus_a.in_count),    32'd0);
      check({tag, "_out_count"}, 32'(bus_a.out_count),   32'd0);
      check({tag, "_img_wr"},    32'(bus_a.img_wr_en),   32'd0);
      check({tag, "_src_rd"},    32'(bus_a.src_rd_en),   32'd0);
      check({tag, "_res_rd"},    32'(bus_a.res_rd_en),   32'd0);
      check({tag, "_snk_wr"},    32'(bus_a.snk_wr_en),   32'd0);
   endtask

   // FIFO environment for dut_a: source FIFO, 1-cycle pipeline FIFO, sink with random back-pressure.
   initial begin
      bit          s_st, i_st, r_st, k_st;
      bit          img_wr, src_rd, res_rd;
      logic [23:0] img_d;
      bus_a.src_empty = 1'b1;
      bus_a.src_dout  = '0;
      bus_a.img_full  = 1'b0;
      bus_a.res_empty = 1'b1;
      bus_a.res_dout  = '0;
      bus_a.snk_full  = 1'b0;
      forever begin
         @(negedge clock);
         cyc++;
         s_st = rand_on && ($urandom_range(0, 3) == 0);
         i_st = rand_on && ($urandom_range(0, 3) == 0);
         r_st = rand_on && ($urandom_range(0, 3) == 0);
         k_st = rand_on && ($urandom_range(0, 3) == 0);
         bus_a.src_empty = s_st || (src_q.size() == 0);
         bus_a.src_dout  = (src_q.size() != 0) ? src_q[0] : 24'd0;
         bus_a.img_full  = force_full || i_st;
         bus_a.res_empty = r_st || (pipe_q.size() == 0) || (res_taken >= out_cap);
         bus_a.res_dout  = (pipe_q.size() != 0) ? pipe_q[0] : 8'd0;
         bus_a.snk_full  = k_st;
         #3;
         img_wr = bus_a.img_wr_en;
         src_rd = bus_a.src_rd_en;
         res_rd = bus_a.res_rd_en;
         img_d  = bus_a.img_din;
         if (img_wr || res_rd) last_xfer_cyc = cyc;
         if (bus_a.done) done_cnt++;
         @(posedge clock);
         #1;
         if (src_rd && (src_q.size() != 0)) void'(src_q.pop_front());
         if (img_wr) pipe_q.push_back(pix_fn(img_d));
         if (res_rd && (pipe_q.size() != 0)) begin
            void'(pipe_q.pop_front());
            res_taken++;
         end
      end
   end

   // Monitor: every sink write is compared against the next expected result in source order.
   initial begin
      logic [7:0] e;
      forever begin
         @(negedge clock);
         #4;
         if (bus_a.snk_wr_en === 1'b1) begin
            snk_cnt++;
            if (exp_q.size() == 0) begin
               check("sink_unexpected_write", 32'(bus_a.snk_din), 32'hffff_ffff);
            end else begin
               e = exp_q.pop_front();
               check("sink_data", 32'(bus_a.snk_din), 32'(e));
            end
         end
      end
   end

   initial begin
      #200000;
      bad++;
      $display("FAIL watchdog: simulation time limit reached");
      $display("test done: total=%0d bad=%0d", total, bad);
      $fatal(1, "watchdog");
   end

   initial begin
      int k;
      int frozen;
      int done_before;
      bit seen_done;
      reset           = 1'b0;
      bus_a.start     = 1'b0;
      bus_b.start     = 1'b0;
      bus_b.src_empty = 1'b1;
      bus_b.src_dout  = '0;
      bus_b.img_full  = 1'b0;
      bus_b.res_empty = 1'b1;
      bus_b.res_dout  = '0;
      bus_b.snk_full  = 1'b0;
      repeat (3) tick();
      check_idle_a("reset");
      reset = 1'b1;
      tick();

      // Abort: only 3 pixels ever arrive, so the timer must expire TIMEOUT cycles after the last move.
      load_pixels(3);
      done_before = done_cnt;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check("to_busy_after_start", 32'(bus_a.busy), 32'd1);
      k = 0;
      while (bus_a.busy && k < 400) begin
         tick();
         k++;
      end
      check("to_wait_bounded", 32'(k < 400), 32'd1);
      check("to_terr", 32'(bus_a.timeout_err), 32'd1);
      check("to_in_count", 32'(bus_a.in_count), 32'd3);
      check("to_out_count", 32'(bus_a.out_count), 32'd3);
      check("to_gap_cycles", 32'(cyc - last_xfer_cyc), 32'(TIMEOUT_A + 1));
      check("to_no_done", 32'(done_cnt - done_before), 32'd0);
      tick();
      check("to_in_count_held", 32'(bus_a.in_count), 32'd3);
      check("to_scoreboard_empty", 32'(exp_q.size()), 32'd0);

      // Full frame with random back-pressure, a 50-cycle img_full stall and start spam.
      load_pixels(N_A);
      rand_on     = 1'b1;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check("f1_busy", 32'(bus_a.busy), 32'd1);
      check("f1_terr_cleared", 32'(bus_a.timeout_err), 32'd0);
      check("f1_in_restart", 32'(bus_a.in_count), 32'd0);
      check("f1_out_restart", 32'(bus_a.out_count), 32'd0);
      k = 0;
      while (bus_a.in_count < 3 && k < 200) begin
         tick();
         k++;
      end
      check("f1_reach3_bounded", 32'(k < 200), 32'd1);
      force_full  = 1'b1;
      bus_a.start = 1'b1;
      frozen      = 0;
      for (int i = 0; i < 50; i++) begin
         tick();
         if (i == 0) frozen = int'(bus_a.in_count);
         check("stall_img_wr", 32'(bus_a.img_wr_en), 32'd0);
         check("stall_src_rd", 32'(bus_a.src_rd_en), 32'd0);
         check("stall_in_frozen", 32'(bus_a.in_count), 32'(frozen));
      end
      check("stall_still_busy", 32'(bus_a.busy), 32'd1);
      force_full  = 1'b0;
      bus_a.start = 1'b0;
      // Next frame's pixels sit in the source early; the count limit must keep them out of this frame.
      load_pixels(N_A);
      k = 0;
      while (!bus_a.done && k < 400) begin
         tick();
         k++;
      end
      check("f1_done_bounded", 32'(k < 400), 32'd1);
      check("f1_done_busy_low", 32'(bus_a.busy), 32'd0);
      check("f1_in_count", 32'(bus_a.in_count), 32'(N_A));
      check("f1_out_count", 32'(bus_a.out_count), 32'(N_A));
      check("f1_done_enables", 32'({bus_a.img_wr_en, bus_a.res_rd_en}), 32'd0);
      tick();
      check("f1_done_one_cycle", 32'(bus_a.done), 32'd0);
      check("f1_idle_busy", 32'(bus_a.busy), 32'd0);
      check("f1_in_held", 32'(bus_a.in_count), 32'(N_A));
      check("f1_src_left", 32'(src_q.size()), 32'(N_A));
      check("f1_scoreboard_left", 32'(exp_q.size()), 32'(N_A));

      // Start on the cycle right after DONE; the result path is capped at 5 to park in DRAIN.
      out_cap     = res_taken + 5;
      bus_a.start = 1'b1;
      tick();
      bus_a.start = 1'b0;
      check("f2_busy", 32'(bus_a.busy), 32'd1);
      check("f2_in_restart", 32'(bus_a.in_count), 32'd0);
      check("f2_out_restart", 32'(bus_a.out_count), 32'd0);
      k = 0;
      while (!(bus_a.in_count == 20'(N_A) && bus_a.out_count == 20'd5) && k < 400) begin
         tick();
         k++;
      end
      check("f2_drain_bounded", 32'(k < 400), 32'd1);
      check("f2_drain_busy", 32'(bus_a.busy), 32'd1);
      reset   = 1'b0;
      out_cap = 1000000;
      tick();
      check_idle_a("midreset");
      reset = 1'b1;
      pipe_q.delete();
      exp_q.delete();
      rand_on = 1'b0;
      tick();
      check_idle_a("postreset");
      check("total_done_pulses", 32'(done_cnt), 32'd1);
      check("total_sink_writes", 32'(snk_cnt), 32'd16);

      // 1x1 frame: the only input and the only output move on the same edge.
      bus_b.src_empty = 1'b0;
      bus_b.src_dout  = 24'habcdef;
      bus_b.res_empty = 1'b0;
      bus_b.res_dout  = 8'h3c;
      tick();
      check("b_idle_enables", 32'({bus_b.img_wr_en, bus_b.src_rd_en, bus_b.res_rd_en, bus_b.snk_wr_en}), 32'd0);
      bus_b.start = 1'b1;
      tick();
      bus_b.start = 1'b0;
      check("b_run_enables", 32'({bus_b.img_wr_en, bus_b.src_rd_en, bus_b.res_rd_en, bus_b.snk_wr_en}), 32'hf);
      check("b_img_din", 32'(bus_b.img_din), 32'habcdef);
      check("b_snk_din", 32'(bus_b.snk_din), 32'h3c);
      tick();
      check("b_done", 32'(bus_b.done), 32'd1);
      check("b_done_busy", 32'(bus_b.busy), 32'd0);
      check("b_in_count", 32'(bus_b.in_count), 32'd1);
      check("b_out_count", 32'(bus_b.out_count), 32'd1);
      check("b_done_enables", 32'({bus_b.img_wr_en, bus_b.res_rd_en}), 32'd0);
      tick();
      check("b_done_cleared", 32'(bus_b.done), 32'd0);
      check("b_idle_enables2", 32'({bus_b.img_wr_en, bus_b.res_rd_en}), 32'd0);

      // 1x1 abort: nothing available, so the frame must end exactly TIMEOUT cycles after start.
      bus_b.src_empty = 1'b1;
      bus_b.res_empty = 1'b1;
      bus_b.start     = 1'b1;
      tick();
      bus_b.start = 1'b0;
      seen_done   = 1'b0;
      k = 1;
      while (bus_b.busy && k < 100) begin
         tick();
         if (bus_b.done) seen_done = 1'b1;
         k++;
      end
      check("b_timeout_cycles", 32'(k), 32'(TIMEOUT_B + 1));
      check("b_timeout_terr", 32'(bus_b.timeout_err), 32'd1);
      check("b_timeout_no_done", 32'(seen_done), 32'd0);
      check("b_timeout_in_count", 32'(bus_b.in_count), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
